shlvw_iter: RTL and testbench

//  Iterative variable-amount left shifter: the left-shift counterpart of the constant right-shift macrocell.

---
 rtl/shlvw_iter_if.sv | 20 ++
 rtl/shlvw_iter.sv | 105 ++++++++++
 tb/tb_shlvw_iter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/shlvw_iter_if.sv
// Operand/result bundle for the iterative left shifter.
interface shlvw_iter_if #(
  parameter int width     = 8,
  parameter int shiftbits = 3
);
  logic                 start;
  logic                 op;
  logic                 pred;
  logic [width-1:0]     i0;
  logic [shiftbits-1:0] i1;
  logic                 busy;
  logic                 o0_valid;
  logic                 o0_enable;
  logic [width-1:0]     o0;

  modport master (output start, op, pred, i0, i1,
                  input  busy, o0_valid, o0_enable, o0);
  modport slave  (input  start, op, pred, i0, i1,
                  output busy, o0_valid, o0_enable, o0);
endinterface

// File: rtl/shlvw_iter.sv
// Iterative left shifter: one amount bit per cycle, MSB first, with optional
// signed saturation. Result pulses o0_valid/o0_enable from a registered DONE stage.
module shlvw_iter #(
  parameter int width     = 8,
  parameter int shiftbits = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  shlvw_iter_if.slave  bus
);
  localparam int CW = (shiftbits > 1) ? $clog2(shiftbits) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               r_state, w_next;
  logic                 r_op, r_pred, r_sign, r_sat;
  logic [shiftbits-1:0] r_amt;
  logic [CW-1:0]        r_cnt;
  logic [width-1:0]     r_acc, r_o0;
  logic                 r_valid, r_en;

  logic [31:0]          w_k;
  logic [width-1:0]     w_shift, w_mask, w_top;
  logic                 w_ovf;

  // One step: shift by 2^cnt; overflow if the bits pushed out (plus new sign) disagree.
  always_comb begin
    w_k     = 32'd1 << r_cnt;
    w_shift = '0;
    w_mask  = '0;
    w_top   = '0;
    w_ovf   = 1'b0;
    if (w_k >= 32'(width)) begin
      w_ovf = |r_acc;
    end else begin
      w_shift = r_acc << w_k;
      w_mask  = ~({width{1'b1}} >> (w_k + 32'd1));
      w_top   = r_acc & w_mask;
      w_ovf   = (w_top != '0) && (w_top != w_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= 1'b0;
      r_pred  <= 1'b0;
      r_sign  <= 1'b0;
      r_sat   <= 1'b0;
      r_amt   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_o0    <= '0;
      r_valid <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE);
      r_en    <= (r_state == DONE) & r_pred;
      case (r_state)
        IDLE: if (bus.start) begin
          r_op   <= bus.op;
          r_pred <= bus.pred;
          r_amt  <= bus.i1;
          r_acc  <= bus.i0;
          r_sign <= bus.i0[width-1];
          r_sat  <= 1'b0;
          r_cnt  <= CW'(shiftbits - 1);
        end
        SHIFT: begin
          if (r_amt[r_cnt]) begin
            r_acc <= w_shift;
            if (r_op && w_ovf) r_sat <= 1'b1;
          end
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        DONE: begin
          if (r_op && r_sat)
            r_o0 <= r_sign ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
          else
            r_o0 <= r_acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.o0_valid  = r_valid;
  assign bus.o0_enable = r_en;
  assign bus.o0        = r_o0;
endmodule

// File: tb/tb_shlvw_iter.sv
// Randomized self-check of shlvw_iter against an arithmetic reference model.
module tb_shlvw_iter;
  localparam int W  = 8;
  localparam int SB = 3;
  localparam int LAT = SB + 1;

  logic clk, reset_n;
  int   errors = 0;
  int   checks = 0;

  shlvw_iter_if #(.width(W), .shiftbits(SB)) bus ();

  shlvw_iter #(.width(W), .shiftbits(SB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Saturating case: exact signed product, clamped to the signed range.
  function automatic logic [W-1:0] ref_shl(input logic op, input logic [W-1:0] a,
                                           input logic [SB-1:0] amt);
    logic [W-1:0] r;
    longint p;
    if (!op) begin
      r = a << amt;
      return r;
    end
    p = longint'($signed(a)) * (longint'(1) << amt);
    if (p > 127)  return 8'h7F;
    if (p < -128) return 8'h80;
    r = p[W-1:0];
    return r;
  endfunction

  task automatic run_op(input logic op, input logic pred, input logic [W-1:0] a,
                        input logic [SB-1:0] amt, input bit spam, input string tag);
    int n;
    logic [W-1:0] exp, held;
    exp = ref_shl(op, a, amt);
    @(negedge clk);
    bus.op = op; bus.pred = pred; bus.i0 = a; bus.i1 = amt; bus.start = 1'b1;
    @(negedge clk);
    n = 0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.o0_valid && n < 20) begin
      bus.start = spam && (n < LAT - 1);
      if (spam) begin
        bus.op = 1'($urandom); bus.pred = 1'($urandom);
        bus.i0 = W'($urandom); bus.i1 = SB'($urandom);
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk({tag, "_valid"}, 32'(bus.o0_valid), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_o0"}, 32'(bus.o0), 32'(exp));
    chk({tag, "_en"}, 32'(bus.o0_enable), 32'(pred));
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    held = bus.o0;
    @(negedge clk);
    chk({tag, "_vdrop"}, {30'd0, bus.o0_valid, bus.o0_enable}, 32'd0);
    chk({tag, "_hold"}, 32'(bus.o0), 32'(held));
    if (spam) begin
      repeat (3) @(negedge clk);
      chk({tag, "_nopulse"}, {30'd0, bus.o0_valid, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.pred = 1'b0; bus.i0 = '0; bus.i1 = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", {bus.o0, bus.busy, bus.o0_valid, bus.o0_enable}, 32'd0);
    reset_n = 1'b1;

    run_op(1'b0, 1'b1, 8'h13, 3'd3, 1'b0, "t1");
    run_op(1'b1, 1'b1, 8'h13, 3'd3, 1'b0, "t2a");
    run_op(1'b1, 1'b1, 8'hF0, 3'd3, 1'b0, "t2b");
    run_op(1'b1, 1'b1, 8'hF0, 3'd4, 1'b0, "t3a");
    run_op(1'b0, 1'b1, 8'hF0, 3'd4, 1'b0, "t3b");
    run_op(1'b1, 1'b1, 8'h00, 3'd7, 1'b0, "t3c");
    run_op(1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, "t4a");
    run_op(1'b1, 1'b1, 8'hA5, 3'd0, 1'b0, "t4b");
    run_op(1'b1, 1'b0, 8'hA5, 3'd0, 1'b0, "t4c");
    run_op(1'b1, 1'b1, 8'h01, 3'd7, 1'b0, "pos_sat");
    run_op(1'b1, 1'b1, 8'hFF, 3'd7, 1'b0, "neg_exact");
    run_op(1'b0, 1'b1, 8'h5A, 3'd7, 1'b1, "t5");

    // Abort mid-SHIFT: outputs clear without waiting for a clock edge.
    @(negedge clk);
    bus.op = 1'b0; bus.pred = 1'b1; bus.i0 = 8'h77; bus.i1 = 3'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk("t6_abort", {bus.o0, bus.busy, bus.o0_valid, bus.o0_enable}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_nopulse", {30'd0, bus.o0_valid, bus.busy}, 32'd0);
    reset_n = 1'b1;
    run_op(1'b1, 1'b1, 8'h21, 3'd2, 1'b0, "t6_after");

    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), 1'($urandom), W'($urandom), SB'($urandom),
             bit'($urandom_range(0, 3) == 0), "rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
